seq_count_bin_down_timer: RTL and testbench

Loadable binary down-counter timer with a valid/ready start request and a valid/ready completion response. It is the countdown counterpart to the team's free-running binary up-counter. A requester loads a count value; the block decrements once per unpaused cycle and holds a done response until the consumer accepts it. It is used as a small programmable delay and timeout engine between control FSMs.

---
 rtl/seq_count_pkg.sv | 17 +
 rtl/seq_count_down_reg.sv | 47 ++++
 rtl/seq_count_bin_down_timer.sv | 99 +++++++++
 tb/tb_seq_count_bin_down_timer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_count_pkg.sv
// -----------------------------------------------------------------------------
// seq_count_pkg
// Shared definitions for the seq_count family of counters.
//   NBITS_DEFAULT : default counter / load-value width
//   state_t       : control states of the down-counter timer
// -----------------------------------------------------------------------------
package seq_count_pkg;

   localparam int NBITS_DEFAULT = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // waiting for a start request
      COUNT = 2'd1,   // decrementing toward zero
      DONE  = 2'd2    // response pending until the consumer accepts it
   } state_t;

endpackage : seq_count_pkg

// File: rtl/seq_count_down_reg.sv
// -----------------------------------------------------------------------------
// seq_count_down_reg
// nbits counter register with load and decrement enables; load wins over dec.
//   clk      : clock, rising edge
//   reset    : synchronous, active-high; clears count to 0
//   load     : capture load_val on the next edge
//   dec      : decrement count by one on the next edge (modulo 2^nbits)
//   load_val : value captured when load is high
//   count    : current register value
// -----------------------------------------------------------------------------
module seq_count_down_reg
   import seq_count_pkg::*;
#(
   parameter int nbits = NBITS_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             dec,
   input  logic [nbits-1:0] load_val,
   output logic [nbits-1:0] count
);

   logic [nbits-1:0] count_next;

   // NOTE: every variable written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      count_next = count;
      if (load) begin
         count_next = load_val;
      end else if (dec) begin
         count_next = count - nbits'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end

endmodule : seq_count_down_reg

// File: rtl/seq_count_bin_down_timer.sv
// -----------------------------------------------------------------------------
// seq_count_bin_down_timer
// Loadable binary down-counter timer. A start handshake loads start_count; the
// counter then decrements once per unpaused cycle and, on reaching zero, holds
// a done response until the consumer accepts it.
//   clk         : clock, rising edge
//   reset       : synchronous, active-high; forces IDLE and count = 0
//   start_val   : start request valid
//   start_rdy   : start request can be accepted (IDLE)
//   start_count : initial count, sampled on the start handshake
//   pause       : freezes the decrement while high (COUNT only)
//   count       : current counter value
//   busy        : high in COUNT and DONE
//   done_val    : countdown complete, response pending
//   done_rdy    : consumer accepts the done response
// All outputs decode registered state only; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module seq_count_bin_down_timer
   import seq_count_pkg::*;
#(
   parameter int nbits = NBITS_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_val,
   output logic             start_rdy,
   input  logic [nbits-1:0] start_count,
   input  logic             pause,
   output logic [nbits-1:0] count,
   output logic             busy,
   output logic             done_val,
   input  logic             done_rdy
);

   state_t state;
   state_t state_next;
   logic   load;
   logic   dec;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      dec        = 1'b0;
      unique case (state)
         IDLE: begin
            // start_rdy is 1 here, so start_val alone completes the handshake.
            if (start_val) begin
               load       = 1'b1;
               state_next = (start_count != '0) ? COUNT : DONE;
            end
         end
         COUNT: begin
            // COUNT is only entered with a nonzero value, so the decrement
            // never wraps: the step from 1 to 0 is also the exit to DONE.
            if (!pause) begin
               dec = 1'b1;
               if (count == nbits'(1)) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            // start_rdy is still 0 in this cycle, so a start can only be
            // accepted from the following IDLE cycle.
            if (done_rdy) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   seq_count_down_reg #(
      .nbits(nbits)
   ) u_down_reg (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .dec      (dec),
      .load_val (start_count),
      .count    (count)
   );

   assign start_rdy = (state == IDLE);
   assign busy      = (state != IDLE);
   assign done_val  = (state == DONE);

endmodule : seq_count_bin_down_timer

// File: tb/tb_seq_count_bin_down_timer.sv
// -----------------------------------------------------------------------------
// tb_seq_count_bin_down_timer
// Self-checking bench: each scenario task pushes the expected per-cycle output
// vector to a scoreboard queue, then steps the clock and compares what the DUT
// shows against the popped entry. Inputs change #1 after the rising edge and
// outputs are sampled there too, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_seq_count_bin_down_timer;

   localparam int NB = 3;

   typedef struct packed {
      logic [NB-1:0] count;
      logic          start_rdy;
      logic          busy;
      logic          done_val;
   } obs_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start_val;
   logic          start_rdy;
   logic [NB-1:0] start_count;
   logic          pause;
   logic [NB-1:0] count;
   logic          busy;
   logic          done_val;
   logic          done_rdy;

   obs_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   seq_count_bin_down_timer #(
      .nbits(NB)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start_val   (start_val),
      .start_rdy   (start_rdy),
      .start_count (start_count),
      .pause       (pause),
      .count       (count),
      .busy        (busy),
      .done_val    (done_val),
      .done_rdy    (done_rdy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic obs_t mk(input int c, input bit sr, input bit b, input bit dv);
      obs_t o;
      o.count     = NB'(c);
      o.start_rdy = sr;
      o.busy      = b;
      o.done_val  = dv;
      return o;
   endfunction

   function automatic obs_t sample();
      return {count, start_rdy, busy, done_val};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset held two cycles, then idle outputs held for 5 more cycles.
   task automatic test_reset();
      obs_t got, want;
      reset = 1'b1; start_val = 1'b0; start_count = '0; pause = 1'b0; done_rdy = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      for (int k = 0; k < 6; k++) exp_q.push_back(mk(0, 1, 0, 0));
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         got  = sample();
         want = exp_q.pop_front();
         n_total++;
         if (got !== want)
            $display("FAIL reset_idle k=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b (count/start_rdy/busy/done_val)",
                     k, got.count, got.start_rdy, got.busy, got.done_val,
                     want.count, want.start_rdy, want.busy, want.done_val);
         else n_pass++;
      end
   endtask

   // Load 5, done held while done_rdy = 0, accepted in T+9, idle in T+10.
   task automatic test_basic_countdown();
      obs_t got, want;
      for (int k = 1; k <= 5; k++) exp_q.push_back(mk(6 - k, 0, 1, 0));
      for (int k = 6; k <= 9; k++) exp_q.push_back(mk(0, 0, 1, 1));
      exp_q.push_back(mk(0, 1, 0, 0));
      start_val = 1'b1; start_count = 3'd5; done_rdy = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         got  = sample();
         want = exp_q.pop_front();
         n_total++;
         if (got !== want)
            $display("FAIL basic k=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b (count/start_rdy/busy/done_val)",
                     k, got.count, got.start_rdy, got.busy, got.done_val,
                     want.count, want.start_rdy, want.busy, want.done_val);
         else n_pass++;
         if (k == 1)  start_val = 1'b0;
         if (k == 9)  done_rdy  = 1'b1;
         if (k == 10) done_rdy  = 1'b0;
      end
   endtask

   // Load 0 (done next cycle), then back-to-back load 7 (no wrap past 1).
   task automatic test_zero_max_loads();
      obs_t got, want;
      exp_q.push_back(mk(0, 0, 1, 1));
      exp_q.push_back(mk(0, 1, 0, 0));
      for (int k = 3; k <= 9; k++) exp_q.push_back(mk(10 - k, 0, 1, 0));
      exp_q.push_back(mk(0, 0, 1, 1));
      exp_q.push_back(mk(0, 0, 1, 1));
      exp_q.push_back(mk(0, 1, 0, 0));
      start_val = 1'b1; start_count = 3'd0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         got  = sample();
         want = exp_q.pop_front();
         n_total++;
         if (got !== want)
            $display("FAIL zero_max k=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b (count/start_rdy/busy/done_val)",
                     k, got.count, got.start_rdy, got.busy, got.done_val,
                     want.count, want.start_rdy, want.busy, want.done_val);
         else n_pass++;
         case (k)
            1:  begin start_val = 1'b0; done_rdy = 1'b1; end
            2:  begin done_rdy = 1'b0; start_val = 1'b1; start_count = 3'd7; end
            3:  start_val = 1'b0;
            11: done_rdy = 1'b1;
            12: done_rdy = 1'b0;
            default: ;
         endcase
      end
   endtask

   // Load 3 with pause high in T+2 and T+3: 3,2,2,2,1 then done in T+6.
   task automatic test_pause();
      obs_t got, want;
      exp_q.push_back(mk(3, 0, 1, 0));
      exp_q.push_back(mk(2, 0, 1, 0));
      exp_q.push_back(mk(2, 0, 1, 0));
      exp_q.push_back(mk(2, 0, 1, 0));
      exp_q.push_back(mk(1, 0, 1, 0));
      exp_q.push_back(mk(0, 0, 1, 1));
      exp_q.push_back(mk(0, 1, 0, 0));
      start_val = 1'b1; start_count = 3'd3;
      for (int k = 1; k <= 7; k++) begin
         tick();
         got  = sample();
         want = exp_q.pop_front();
         n_total++;
         if (got !== want)
            $display("FAIL pause k=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b (count/start_rdy/busy/done_val)",
                     k, got.count, got.start_rdy, got.busy, got.done_val,
                     want.count, want.start_rdy, want.busy, want.done_val);
         else n_pass++;
         case (k)
            1: start_val = 1'b0;
            2: pause     = 1'b1;
            4: pause     = 1'b0;
            6: done_rdy  = 1'b1;
            7: done_rdy  = 1'b0;
            default: ;
         endcase
      end
   endtask

   // start_val held high with 6 throughout a countdown of 2: only the cycle
   // after the done handshake accepts it.
   task automatic test_start_ignored_while_busy();
      obs_t got, want;
      exp_q.push_back(mk(2, 0, 1, 0));
      exp_q.push_back(mk(1, 0, 1, 0));
      exp_q.push_back(mk(0, 0, 1, 1));
      exp_q.push_back(mk(0, 1, 0, 0));
      exp_q.push_back(mk(6, 0, 1, 0));
      exp_q.push_back(mk(5, 0, 1, 0));
      start_val = 1'b1; start_count = 3'd2;
      for (int k = 1; k <= 6; k++) begin
         tick();
         got  = sample();
         want = exp_q.pop_front();
         n_total++;
         if (got !== want)
            $display("FAIL start_busy k=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b (count/start_rdy/busy/done_val)",
                     k, got.count, got.start_rdy, got.busy, got.done_val,
                     want.count, want.start_rdy, want.busy, want.done_val);
         else n_pass++;
         case (k)
            1: start_count = 3'd6;
            3: done_rdy    = 1'b1;
            4: done_rdy    = 1'b0;
            5: start_val   = 1'b0;
            default: ;
         endcase
      end
   endtask

   // Reset from COUNT (count = 2), from DONE with done pending, and from IDLE
   // with a start request present.
   task automatic test_reset_mid_operation();
      obs_t got, want;
      exp_q.push_back(mk(0, 1, 0, 0));
      exp_q.push_back(mk(4, 0, 1, 0));
      exp_q.push_back(mk(3, 0, 1, 0));
      exp_q.push_back(mk(2, 0, 1, 0));
      exp_q.push_back(mk(0, 1, 0, 0));
      exp_q.push_back(mk(0, 0, 1, 1));
      exp_q.push_back(mk(0, 1, 0, 0));
      exp_q.push_back(mk(0, 1, 0, 0));
      exp_q.push_back(mk(0, 1, 0, 0));
      reset = 1'b1; start_val = 1'b0; pause = 1'b0; done_rdy = 1'b0;
      for (int k = 0; k <= 8; k++) begin
         tick();
         got  = sample();
         want = exp_q.pop_front();
         n_total++;
         if (got !== want)
            $display("FAIL reset_mid k=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b (count/start_rdy/busy/done_val)",
                     k, got.count, got.start_rdy, got.busy, got.done_val,
                     want.count, want.start_rdy, want.busy, want.done_val);
         else n_pass++;
         case (k)
            0: begin reset = 1'b0; start_val = 1'b1; start_count = 3'd4; end
            1: start_val = 1'b0;
            3: reset = 1'b1;
            4: begin reset = 1'b0; start_val = 1'b1; start_count = 3'd0; end
            5: begin reset = 1'b1; start_val = 1'b0; end
            6: begin reset = 1'b1; start_val = 1'b1; start_count = 3'd5; end
            7: begin reset = 1'b0; start_val = 1'b0; end
            default: ;
         endcase
      end
   endtask

   initial begin
      test_reset();
      test_basic_countdown();
      test_zero_max_loads();
      test_pause();
      test_start_ignored_while_busy();
      test_reset_mid_operation();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_seq_count_bin_down_timer
